// File: rtl/pcecd_scsi_initiator.sv
// Host-side initiator for the PC Engine CD SCSI-style bus: selects the drive, sends a
// queued command block, streams data-in to the host and captures status/message.
module pcecd_scsi_initiator #(
  parameter int CMD_DEPTH   = 16,
  parameter int SEL_TIMEOUT = 1024,
  parameter int RST_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_wr_en,
  input  logic [7:0] cmd_wr_data,
  output logic       cmd_full,
  input  logic       start,
  input  logic       bus_reset_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] status_byte,
  output logic [7:0] message_byte,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  input  logic       tgt_bsy,
  input  logic       tgt_req,
  input  logic       tgt_msg,
  input  logic       tgt_cd,
  input  logic       tgt_io,
  input  logic [7:0] tgt_db,
  output logic [7:0] init_db,
  output logic       init_db_oe,
  output logic       init_sel,
  output logic       init_ack,
  output logic       init_rst
);
  localparam int AW      = $clog2(CMD_DEPTH);
  localparam int CNT_MAX = (SEL_TIMEOUT > RST_CYCLES) ? SEL_TIMEOUT : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] PH_DIN  = 3'b001;
  localparam logic [2:0] PH_CMD  = 3'b010;
  localparam logic [2:0] PH_STAT = 3'b011;
  localparam logic [2:0] PH_MSGI = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WAIT_PHASE, S_CMD_SETUP,
    S_CMD_ACK, S_DIN_HOLD, S_XFER_ACK, S_BUS_RESET
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [CMD_DEPTH];
  logic            msg_seen_q, msg_seen_d;
  logic            done_q, done_d, error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [7:0]      status_q, status_d, message_q, message_d, data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic [7:0]      init_db_q, init_db_d;
  logic            init_db_oe_q, init_db_oe_d, init_sel_q, init_sel_d;
  logic            init_ack_q, init_ack_d, init_rst_q, init_rst_d;
  logic            fifo_empty, fifo_full, push, fifo_clr;
  logic [2:0]      phase;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = cmd_wr_en && !fifo_full && (state_q == S_IDLE) && !bus_reset_req;
  assign phase      = {tgt_msg, tgt_cd, tgt_io};

  // NOTE: the command store has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_wr_data;
  end

  always_comb begin
    // NOTE: every *_d starts from its *_q (pulses from 0) so no branch can infer a latch.
    state_d      = state_q;      cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;     rd_ptr_d     = rd_ptr_q;
    msg_seen_d   = msg_seen_q;   done_d       = 1'b0;
    error_d      = 1'b0;         err_code_d   = err_code_q;
    status_d     = status_q;     message_d    = message_q;
    data_out_d   = data_out_q;   data_valid_d = data_valid_q;
    init_db_d    = init_db_q;    init_db_oe_d = init_db_oe_q;
    init_sel_d   = init_sel_q;   init_ack_d   = init_ack_q;
    init_rst_d   = init_rst_q;   fifo_clr     = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case (state_q)
      S_IDLE: if (start && !fifo_empty && !tgt_bsy) begin
        state_d = S_SELECT; init_sel_d = 1'b1; cnt_d = '0;
        err_code_d = 2'd0;  msg_seen_d = 1'b0;
      end
      S_SELECT: begin
        if (tgt_bsy) begin
          init_sel_d = 1'b0; state_d = S_WAIT_PHASE;
        end else if (cnt_q == CW'(SEL_TIMEOUT - 1)) begin
          init_sel_d = 1'b0; error_d = 1'b1; err_code_d = 2'd1;
          fifo_clr = 1'b1;   state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_PHASE: if (!init_ack_q) begin
        if (!tgt_bsy) begin
          // Bus free is only a clean end once the message-in byte has been taken.
          if (msg_seen_q) done_d = 1'b1;
          else begin error_d = 1'b1; err_code_d = 2'd3; end
          fifo_clr = 1'b1; state_d = S_IDLE;
        end else if (tgt_req) begin
          case (phase)
            PH_CMD: if (fifo_empty) begin
              error_d = 1'b1; err_code_d = 2'd2; fifo_clr = 1'b1; state_d = S_IDLE;
            end else begin
              init_db_d = mem_q[rd_ptr_q[AW-1:0]]; init_db_oe_d = 1'b1; state_d = S_CMD_SETUP;
            end
            PH_DIN:  begin data_out_d = tgt_db; data_valid_d = 1'b1; state_d = S_DIN_HOLD; end
            PH_STAT: begin status_d = tgt_db; state_d = S_XFER_ACK; end
            PH_MSGI: begin message_d = tgt_db; msg_seen_d = 1'b1; state_d = S_XFER_ACK; end
            default: begin
              error_d = 1'b1; err_code_d = 2'd2; fifo_clr = 1'b1; state_d = S_IDLE;
            end
          endcase
        end
      end
      S_CMD_SETUP: begin init_ack_d = 1'b1; state_d = S_CMD_ACK; end
      S_CMD_ACK: if (!tgt_req) begin
        init_ack_d = 1'b0; init_db_oe_d = 1'b0; init_db_d = 8'h00;
        rd_ptr_d = rd_ptr_q + 1'b1; state_d = S_WAIT_PHASE;
      end
      S_DIN_HOLD: if (data_ready) begin
        data_valid_d = 1'b0; init_ack_d = 1'b1; state_d = S_XFER_ACK;
      end
      S_XFER_ACK: begin
        if (!init_ack_q) init_ack_d = 1'b1;
        else if (!tgt_req) begin init_ack_d = 1'b0; state_d = S_WAIT_PHASE; end
      end
      S_BUS_RESET: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin init_rst_d = 1'b0; state_d = S_IDLE; end
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus_reset_req) begin
      state_d = S_BUS_RESET; init_rst_d = 1'b1; cnt_d = '0;
      done_d = 1'b0; error_d = 1'b0; data_valid_d = 1'b0; msg_seen_d = 1'b0;
      init_sel_d = 1'b0; init_ack_d = 1'b0; init_db_oe_d = 1'b0; init_db_d = 8'h00;
      fifo_clr = 1'b1;
    end
    if (fifo_clr) begin wr_ptr_d = '0; rd_ptr_d = '0; end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  cnt_q <= '0;  wr_ptr_q <= '0;  rd_ptr_q <= '0;
      msg_seen_q <= 1'b0; done_q <= 1'b0; error_q <= 1'b0; err_code_q <= 2'd0;
      status_q <= 8'h00;  message_q <= 8'h00; data_out_q <= 8'h00; data_valid_q <= 1'b0;
      init_db_q <= 8'h00; init_db_oe_q <= 1'b0; init_sel_q <= 1'b0;
      init_ack_q <= 1'b0; init_rst_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;
      msg_seen_q <= msg_seen_d; done_q <= done_d; error_q <= error_d; err_code_q <= err_code_d;
      status_q <= status_d; message_q <= message_d; data_out_q <= data_out_d;
      data_valid_q <= data_valid_d; init_db_q <= init_db_d; init_db_oe_q <= init_db_oe_d;
      init_sel_q <= init_sel_d; init_ack_q <= init_ack_d; init_rst_q <= init_rst_d;
    end
  end

  assign cmd_full     = fifo_full;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign status_byte  = status_q;
  assign message_byte = message_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign init_db      = init_db_q;
  assign init_db_oe   = init_db_oe_q;
  assign init_sel     = init_sel_q;
  assign init_ack     = init_ack_q;
  assign init_rst     = init_rst_q;
endmodule

// File: tb/tb_pcecd_scsi_initiator.sv
// Randomized bench for pcecd_scsi_initiator: a bench-side target drives bus phases and
// results are compared with expectations built from queued command and data bytes.
module tb_pcecd_scsi_initiator;
  localparam int CMD_DEPTH   = 16;
  localparam int SEL_TIMEOUT = 1024;
  localparam int RST_CYCLES  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_wr_en = 1'b0;
  logic [7:0] cmd_wr_data = 8'h00;
  logic       cmd_full;
  logic       start = 1'b0;
  logic       bus_reset_req = 1'b0;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [7:0] status_byte, message_byte, data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       tgt_bsy = 1'b0, tgt_req = 1'b0, tgt_msg = 1'b0, tgt_cd = 1'b0, tgt_io = 1'b0;
  logic [7:0] tgt_db = 8'h00;
  logic [7:0] init_db;
  logic       init_db_oe, init_sel, init_ack, init_rst;

  pcecd_scsi_initiator #(
    .CMD_DEPTH(CMD_DEPTH), .SEL_TIMEOUT(SEL_TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
    .cmd_full(cmd_full), .start(start), .bus_reset_req(bus_reset_req), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .status_byte(status_byte),
    .message_byte(message_byte), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .tgt_bsy(tgt_bsy), .tgt_req(tgt_req), .tgt_msg(tgt_msg),
    .tgt_cd(tgt_cd), .tgt_io(tgt_io), .tgt_db(tgt_db), .init_db(init_db),
    .init_db_oe(init_db_oe), .init_sel(init_sel), .init_ack(init_ack), .init_rst(init_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] cmd_q[$];    // reference contents of the command FIFO
  logic [7:0] din_q[$];    // data-in bytes the target will send
  int         stall_q[$];  // host stall cycles per data-in byte
  logic [7:0] got_q[$];    // bytes the host accepted
  int  host_stall = 0;
  int  stall_left = 0;
  bit  seen_valid = 1'b0;
  int  done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
  logic [7:0] exp_status = 8'h00, exp_msg = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Host: applies the configured stall to each new data_out, then accepts it.
  always @(negedge clk) begin
    if (!data_valid) begin
      data_ready = 1'b0;
      seen_valid = 1'b0;
    end else begin
      if (!seen_valid) begin stall_left = host_stall; seen_valid = 1'b1; end
      if (stall_left > 0) begin
        data_ready = 1'b0;
        stall_left--;
      end else begin
        data_ready = 1'b1;
        got_q.push_back(data_out);
      end
    end
  end

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic push_cmd(input logic [7:0] b);
    cmd_wr_en = 1'b1; cmd_wr_data = b;
    if (cmd_q.size() < CMD_DEPTH) cmd_q.push_back(b);
    step();
    cmd_wr_en = 1'b0;
    check("cmd_full", cmd_full, cmd_q.size() == CMD_DEPTH);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic check_start_ignored();
    pulse_start();
    check("start_ignored_sel", init_sel, 1'b0);
    check("start_ignored_busy", busy, 1'b0);
  endtask

  task automatic tgt_cmd_byte(input logic [7:0] exp);
    {tgt_msg, tgt_cd, tgt_io} = 3'b010; tgt_req = 1'b1;
    step();
    check("cmd_setup_oe", init_db_oe, 1'b1);
    check("cmd_setup_noack", init_ack, 1'b0);
    check("cmd_setup_db", init_db, exp);
    step();
    check("cmd_ack", init_ack, 1'b1);
    check("cmd_ack_db", init_db, exp);
    tgt_req = 1'b0;
    step();
    check("cmd_ack_fall", init_ack, 1'b0);
    check("cmd_oe_fall", init_db_oe, 1'b0);
  endtask

  task automatic tgt_in_byte(input logic [2:0] ph, input logic [7:0] val, input int stall);
    int lat;
    lat = 0;
    host_stall = stall;
    {tgt_msg, tgt_cd, tgt_io} = ph; tgt_db = val; tgt_req = 1'b1;
    do begin step(); lat++; end while (!init_ack && lat < 64);
    check("in_ack_latency", lat, 2 + stall);
    tgt_req = 1'b0;
    step();
    check("in_ack_release", init_ack, 1'b0);
  endtask

  // mode 0: clean completion; 1: bus free without message; 2: extra command byte request
  task automatic run_txn(input int take, input int mode, input logic [7:0] st, input logic [7:0] mg);
    logic [7:0] exp_cmd[$];
    int base;
    exp_cmd = cmd_q;
    cmd_q.delete();
    base = got_q.size();
    pulse_start();
    check("sel_rise", init_sel, 1'b1);
    check("busy_rise", busy, 1'b1);
    tgt_bsy = 1'b1;
    step();
    check("sel_fall", init_sel, 1'b0);
    for (int i = 0; i < take; i++) tgt_cmd_byte(exp_cmd[i]);
    if (mode == 2) begin
      {tgt_msg, tgt_cd, tgt_io} = 3'b010; tgt_req = 1'b1;
      step();
      check("proto_error", error, 1'b1);
      check("proto_code", err_code, 2'd2);
      check("proto_ack", init_ack, 1'b0);
      exp_err++;
      tgt_req = 1'b0; tgt_bsy = 1'b0;
      step();
      check("proto_idle", busy, 1'b0);
    end else begin
      for (int i = 0; i < din_q.size(); i++) tgt_in_byte(3'b001, din_q[i], stall_q[i]);
      tgt_in_byte(3'b011, st, 0);
      exp_status = st;
      if (mode == 0) begin tgt_in_byte(3'b111, mg, 0); exp_msg = mg; end
      tgt_bsy = 1'b0; {tgt_msg, tgt_cd, tgt_io} = 3'b000;
      step();
      check("end_done", done, mode == 0);
      check("end_error", error, mode == 1);
      check("end_code", err_code, (mode == 1) ? 2'd3 : 2'd0);
      check("status_byte", status_byte, exp_status);
      check("message_byte", message_byte, exp_msg);
      check("din_count", got_q.size() - base, din_q.size());
      for (int i = 0; i < din_q.size() && base + i < got_q.size(); i++)
        check("din_data", got_q[base + i], din_q[i]);
      if (mode == 0) exp_done++; else exp_err++;
      step();
      check("end_pulse_clear", done | error, 1'b0);
      check("end_busy", busy, 1'b0);
    end
    check_start_ignored();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mode, take, cnt, snap_d, snap_e;
    logic [7:0] st, mg;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_outs", {cmd_full, done, error, data_valid, init_db_oe, init_sel, init_ack, init_rst}, 8'h00);
    check("rst_err_code", err_code, 2'd0);
    check("rst_status", status_byte, 8'h00);
    check("rst_message", message_byte, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_init_db", init_db, 8'h00);
    rst_n = 1'b1;
    step();
    check_start_ignored();

    // Six-byte command, status 0, message 0.
    foreach (cmd_q[i]) ; // nothing queued yet
    push_cmd(8'h08); push_cmd(8'h00); push_cmd(8'h00);
    push_cmd(8'h10); push_cmd(8'h01); push_cmd(8'h00);
    din_q.delete(); stall_q.delete();
    run_txn(6, 0, 8'h00, 8'h00);

    // Three data-in bytes with a 5-cycle host stall on the second.
    push_cmd(8'h28);
    din_q = '{8'hA5, 8'h5A, 8'hFF}; stall_q = '{0, 5, 0};
    run_txn(1, 0, 8'h00, 8'h00);

    // One byte queued, target asks for a second.
    push_cmd(8'h12);
    run_txn(1, 2, 8'h00, 8'h00);

    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) push_cmd(8'($urandom));
      mode = $urandom_range(0, 5);
      mode = (mode <= 3) ? 0 : ((mode == 4) ? 1 : 2);
      take = (mode == 2) ? n : $urandom_range(1, n);
      din_q.delete(); stall_q.delete();
      repeat ($urandom_range(0, 4)) begin
        din_q.push_back(8'($urandom));
        stall_q.push_back($urandom_range(0, 3));
      end
      st = 8'($urandom); mg = 8'($urandom);
      run_txn(take, mode, st, mg);
    end

    // Overfill the FIFO: the 17th byte is dropped, so a 17th request is a protocol error.
    for (int i = 0; i < CMD_DEPTH + 1; i++) push_cmd(8'($urandom));
    run_txn(CMD_DEPTH, 2, 8'h00, 8'h00);

    // Start ignored while the bus is busy; the queued byte is then used normally.
    push_cmd(8'h00);
    tgt_bsy = 1'b1;
    pulse_start();
    check("bsy_start_ignored", init_sel, 1'b0);
    tgt_bsy = 1'b0;
    step();
    din_q.delete(); stall_q.delete();
    run_txn(1, 0, 8'h02, 8'h00);

    // Selection timeout.
    push_cmd(8'h12);
    cmd_q.delete();
    pulse_start();
    check("to_sel_rise", init_sel, 1'b1);
    cnt = 0;
    do begin step(); cnt++; end while (!error && cnt < 1200);
    check("to_cycles", cnt, SEL_TIMEOUT);
    check("to_code", err_code, 2'd1);
    check("to_sel_low", init_sel, 1'b0);
    exp_err++;
    step();
    check_start_ignored();

    // Bus reset in the middle of a stalled data-in byte.
    push_cmd(8'hAA); push_cmd(8'hBB);
    pulse_start();
    tgt_bsy = 1'b1;
    step();
    tgt_cmd_byte(cmd_q[0]);
    cmd_q.delete();
    host_stall = 100;
    {tgt_msg, tgt_cd, tgt_io} = 3'b001; tgt_db = 8'h77; tgt_req = 1'b1;
    repeat (3) step();
    check("br_valid_before", data_valid, 1'b1);
    snap_d = done_cnt; snap_e = err_cnt;
    bus_reset_req = 1'b1; tgt_req = 1'b0; tgt_bsy = 1'b0;
    step();
    bus_reset_req = 1'b0; host_stall = 0;
    check("br_valid", data_valid, 1'b0);
    check("br_ack", init_ack, 1'b0);
    check("br_busy", busy, 1'b1);
    cnt = 0;
    while (init_rst && cnt < 50) begin cnt++; step(); end
    check("br_rst_cycles", cnt, RST_CYCLES);
    check("br_idle", busy, 1'b0);
    check("br_no_done", done_cnt, snap_d);
    check("br_no_error", err_cnt, snap_e);
    check_start_ignored();

    step();
    check("total_done", done_cnt, exp_done);
    check("total_error", err_cnt, exp_err);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
